frame_update_scheduler: RTL and testbench
=========================================

Name: frame_update_scheduler

Overview:
- Sequences the per-frame game-state updates (dino, obstacles, clouds, ground, score) during vertical blanking.
- Triggered by the VGA timing generator's one-tick end-of-active pulse `animate`.
- Grants each enabled update client one exclusive req/done window, in fixed index order.
- Flags frames where the sequence did not finish before the next frame boundary, `screened`.

Parameters:
- N_CLIENTS, 5, number of update clients (1..16).
- FCNT_W, 16, width of the frame counter.
- TIMEOUT_CYC, 4096, per-client watchdog limit in clk cycles; used only with SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  game running; gates the start of new sequences
- animate  in  1  one-tick pulse at the last active pixel of a frame
- screened  in  1  one-tick pulse at end of frame (deadline)
- client_en  in  N_CLIENTS  per-client participation mask, sampled at sequence start
- upd_done  in  N_CLIENTS  client i finished its update; level, sampled while its req is high
- clr_err  in  1  clears the sticky error flags
- upd_req  out  N_CLIENTS  one-hot (or zero) update grant
- busy  out  1  sequence in progress
- frame_cnt  out  FCNT_W  count of accepted sequences
- overrun  out  1  sticky: `animate` arrived while busy
- late  out  1  sticky: `screened` arrived while busy
- timeout_err  out  1  sticky: client watchdog fired; constant 0 without SCHED_TIMEOUT_EN

Behaviour:
- Reset values: state IDLE; upd_req=0; busy=0; frame_cnt=0; overrun=0; late=0; timeout_err=0; pending=0. A reset mid-sequence drops upd_req at the same edge, with no completion.
- States: IDLE, SELECT, WAIT.
- IDLE:
  - When animate=1 and enable=1 at edge k: pending<=client_en; frame_cnt<=frame_cnt+1 (wraps modulo 2^FCNT_W); busy<=1; go to SELECT.
  - animate with enable=0 is ignored.
- SELECT:
  - If pending==0: busy<=0, go to IDLE. A zero mask therefore still counts a frame, is busy for 1 cycle and issues no req.
  - Otherwise: cur<=lowest set bit of pending; upd_req<=onehot(cur); go to WAIT.
  - First req is high after edge k+1, i.e. 2-edge latency from sampled animate.
- WAIT:
  - upd_req holds until upd_done[cur]=1 is sampled. At that edge: upd_req<=0; pending[cur]<=0; go to SELECT.
  - There is therefore a mandatory 1-cycle req-low gap between clients.
  - upd_done bits of non-selected clients are ignored. upd_done already high when req rises completes in 1 cycle.
- enable falling mid-sequence does not abort; the sequence finishes.
- client_en changes mid-sequence have no effect until the next start.
- animate while busy=1: overrun<=1; frame_cnt unchanged; pulse discarded.
- screened while busy=1: late<=1; sequence continues.
- clr_err=1: clears overrun, late and timeout_err. A set condition on the same edge wins over clear.
- busy falls on the edge where SELECT finds pending==0.

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- When defined:
  - A watchdog counter, width clog2(TIMEOUT_CYC+1), resets on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYC without done: upd_req<=0; pending[cur]<=0; timeout_err<=1; go to SELECT.
  - done and timeout on the same edge: done wins, no error.
- When undefined: no counter logic; timeout_err is tied 0; WAIT is unbounded.

Decomposition:
- Shared package vga_pkg holds:
  - the state encoding typedef (IDLE/SELECT/WAIT);
  - the FCNT_W and N_CLIENTS defaults;
  - the TIMEOUT_CYC default.
- One sub-module, sched_prio_enc: a parameterised combinational lowest-set-bit encoder (input mask, output index plus valid), instantiated by the scheduler.

Test Plan:
- Basic sequence:
  - Stimulus: client_en=5'b10101; animate at cycle 10; each client returns done 3 cycles after its req.
  - Response: req order 0,2,4 with 1-cycle gaps; first req high at cycle 12; busy falls after client 4; frame_cnt=1.
- Zero mask:
  - Stimulus: client_en=0, animate.
  - Response: no upd_req; busy high exactly 1 cycle; frame_cnt increments.
- Overrun and late:
  - Stimulus: client 1 holds done low; pulse screened, then animate.
  - Response: late=1 then overrun=1; frame_cnt not incremented by the second animate; clr_err returns both to 0.
- Reset mid-WAIT:
  - Stimulus: rst while upd_req=5'b00010.
  - Response: after that edge all outputs are 0; the next animate restarts from client 0.
- Gating and spurious done:
  - Stimulus: enable=0 with animate → no activity. Done of an unselected client → ignored, no state change.
- SCHED_TIMEOUT_EN with TIMEOUT_CYC=8, client 0 never done:
  - Response: req drops after 8 WAIT cycles; timeout_err=1; client 1 served next.
  - Second stimulus: done exactly on cycle 8 → no error.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vga_pkg
// Description : Shared types and defaults for the per-frame update scheduler.
//               Holds the scheduler state encoding, the default client count,
//               frame-counter width and watchdog limit, plus a helper that
//               sizes index fields safely for a single-client build.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Scheduler states; explicit 2-bit encoding so the register width is fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_WAIT   = 2'd2
  } sched_state_t;

  localparam int N_CLIENTS_DEF   = 5;
  localparam int FCNT_W_DEF      = 16;
  localparam int TIMEOUT_CYC_DEF = 4096;

  // Width of an index into an N-entry vector; never zero, even for N == 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sched_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : sched_prio_enc
// Description : Combinational lowest-set-bit priority encoder. Client 0 has
//               the highest priority, which gives the scheduler its fixed
//               ascending service order.
// Ports       : i_mask  [W-1:0]     request mask
//               o_idx   [IDX_W-1:0] index of the lowest set bit (0 if none)
//               o_valid             at least one bit of i_mask is set
// Revision    : 1.0 - initial release
// ============================================================================
module sched_prio_enc
  import vga_pkg::*;
#(
  parameter int W     = N_CLIENTS_DEF,
  parameter int IDX_W = idx_width(W)
) (
  input  logic [W-1:0]     i_mask,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the top down so the last (lowest) set bit found wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_update_scheduler
// Description : Runs the per-frame game-state updates during vertical
//               blanking. An `animate` pulse (with `enable`) snapshots the
//               client_en mask and counts a frame; every enabled client then
//               receives one exclusive upd_req window, lowest index first,
//               that closes when its upd_done is sampled high. Sticky flags
//               record a second animate while busy (overrun) and a frame
//               boundary reached while busy (late).
// Optional    : `define SCHED_TIMEOUT_EN adds a per-client watchdog of
//               TIMEOUT_CYC cycles that abandons a stalled client and raises
//               timeout_err. Without it timeout_err is constant 0.
// Ports       : clk, rst        clock, synchronous active-high reset
//               enable          allows new sequences to start
//               animate         end-of-active-video start pulse
//               screened        end-of-frame deadline pulse
//               client_en       participation mask, sampled at start
//               upd_done        per-client completion level
//               clr_err         clears overrun/late/timeout_err
//               upd_req         one-hot (or zero) update grant
//               busy            sequence in progress
//               frame_cnt       accepted sequences, wraps
//               overrun, late, timeout_err  sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module frame_update_scheduler
  import vga_pkg::*;
#(
  parameter int N_CLIENTS   = N_CLIENTS_DEF,
  parameter int FCNT_W      = FCNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 animate,
  input  logic                 screened,
  input  logic [N_CLIENTS-1:0] client_en,
  input  logic [N_CLIENTS-1:0] upd_done,
  input  logic                 clr_err,
  output logic [N_CLIENTS-1:0] upd_req,
  output logic                 busy,
  output logic [FCNT_W-1:0]    frame_cnt,
  output logic                 overrun,
  output logic                 late,
  output logic                 timeout_err
);

  localparam int IDX_W = idx_width(N_CLIENTS);

  // Elaboration-time guard on the configuration range.
  if ((N_CLIENTS < 1) || (N_CLIENTS > 16) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
    $error("frame_update_scheduler: N_CLIENTS must be 1..16 and TIMEOUT_CYC >= 1");
  end

  sched_state_t         r_state;
  sched_state_t         w_state_nxt;
  logic [N_CLIENTS-1:0] r_pending;
  logic [IDX_W-1:0]     r_cur;
  logic [FCNT_W-1:0]    r_frame_cnt;
  logic                 r_overrun;
  logic                 r_late;

  logic [IDX_W-1:0]     w_enc_idx;
  logic                 w_enc_valid;
  logic [N_CLIENTS-1:0] w_cur_onehot;
  logic                 w_done_cur;
  logic                 w_timeout_fire;
  logic                 w_finish;
  logic                 w_start;

  // Lowest pending client is the next one served.
  sched_prio_enc #(
    .W     (N_CLIENTS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_mask  (r_pending),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  assign w_cur_onehot = N_CLIENTS'(1'b1) << r_cur;
  // Only the granted client's done bit matters; the others are ignored.
  assign w_done_cur   = |(upd_done & w_cur_onehot);
  assign w_start      = (r_state == ST_IDLE) && animate && enable;
  // A done on the watchdog's final cycle still counts as a normal completion.
  assign w_finish     = w_done_cur || w_timeout_fire;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        // An empty mask still passes through SELECT once, so a frame with no
        // participants is busy for exactly one cycle.
        w_state_nxt = w_enc_valid ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        // Returning through SELECT leaves upd_req low for one cycle between
        // consecutive clients.
        if (w_finish) begin
          w_state_nxt = ST_SELECT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs, decoded from the registered state so they are glitch-free
  // and drop on the same edge as a reset or a completion.
  // --------------------------------------------------------------------------
  always_comb begin
    upd_req = '0;
    busy    = 1'b0;
    case (r_state)
      ST_SELECT: begin
        busy = 1'b1;
      end
      ST_WAIT: begin
        busy    = 1'b1;
        upd_req = w_cur_onehot;
      end
      default: begin
        busy    = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequence datapath: mask snapshot, current client, frame counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_cur       <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_start) begin
        r_pending   <= client_en;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if ((r_state == ST_SELECT) && w_enc_valid) begin
        r_cur <= w_enc_idx;
      end
      if ((r_state == ST_WAIT) && w_finish) begin
        r_pending <= r_pending & ~w_cur_onehot;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags; a new event on the clearing edge keeps the flag set.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
      r_late    <= 1'b0;
    end else begin
      if (animate && busy) begin
        r_overrun <= 1'b1;
      end else if (clr_err) begin
        r_overrun <= 1'b0;
      end
      if (screened && busy) begin
        r_late <= 1'b1;
      end else if (clr_err) begin
        r_late <= 1'b0;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign overrun   = r_overrun;
  assign late      = r_late;

`ifdef SCHED_TIMEOUT_EN
  // --------------------------------------------------------------------------
  // Per-client watchdog. Cleared in SELECT so it starts at 0 on WAIT entry;
  // fires on the TIMEOUT_CYC-th WAIT edge, i.e. after TIMEOUT_CYC req cycles.
  // --------------------------------------------------------------------------
  localparam int              WD_W        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] c_wdog_last = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_timeout_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (r_state == ST_SELECT) begin
      r_wdog <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout_fire = (r_state == ST_WAIT) && !w_done_cur &&
                          (r_wdog == c_wdog_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout_fire) begin
      r_timeout_err <= 1'b1;
    end else if (clr_err) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  // No watchdog: a client may hold its window indefinitely.
  assign w_timeout_fire = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_update_scheduler
// Description : Self-checking bench for frame_update_scheduler. A client
//               responder returns done a programmable number of cycles after
//               each grant; expected grant/busy timelines are computed per
//               frame from the service rules with plain arithmetic.
//               Watchdog scenarios are compiled in with SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_update_scheduler;

  localparam int N  = 5;
  localparam int FW = 16;
  localparam int TO = 8;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          animate;
  logic          screened;
  logic [N-1:0]  client_en;
  logic [N-1:0]  upd_done;
  logic          clr_err;
  logic [N-1:0]  upd_req;
  logic          busy;
  logic [FW-1:0] frame_cnt;
  logic          overrun;
  logic          late;
  logic          timeout_err;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [FW-1:0] m_fcnt      = '0;
  bit            m_late      = 1'b0;
  bit            m_overrun   = 1'b0;
  bit            m_tout      = 1'b0;
  int            lat_cfg[N];
  int            hi_cnt[N];

  frame_update_scheduler #(
    .N_CLIENTS   (N),
    .FCNT_W      (FW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .animate     (animate),
    .screened    (screened),
    .client_en   (client_en),
    .upd_done    (upd_done),
    .clr_err     (clr_err),
    .upd_req     (upd_req),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .late        (late),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Advance to the next falling edge, then drive the client responder:
  // a participating client raises done once its req has been high lat_cfg
  // cycles (lat 0 = done held high before the grant); others toggle randomly.
  task automatic tick(input logic [N-1:0] m);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (upd_req[i]) hi_cnt[i]++;
      else            hi_cnt[i] = 0;
      if (m[i]) upd_done[i] = (lat_cfg[i] == 0) || (upd_req[i] && hi_cnt[i] >= lat_cfg[i]);
      else      upd_done[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_flags(input string tag);
    vectors += 3;
    if (late !== m_late) begin
      miscompares++;
      $display("FAIL %s late: got %b expected %b", tag, late, m_late);
    end
    if (overrun !== m_overrun) begin
      miscompares++;
      $display("FAIL %s overrun: got %b expected %b", tag, overrun, m_overrun);
    end
    if (timeout_err !== m_tout) begin
      miscompares++;
      $display("FAIL %s timeout_err: got %b expected %b", tag, timeout_err, m_tout);
    end
  endtask

  // One complete frame: start, then compare req/busy on every cycle against a
  // timeline built from the mask and the response latencies. With rnd set,
  // screened/enable/client_en are perturbed during the frame.
  task automatic run_frame(input logic [N-1:0] mask, input bit rnd, input string tag);
    logic [N-1:0] exp_req[64];
    bit           exp_busy[64];
    logic [N-1:0] one = 1;
    int           t, h, len;
    bit           tout_hit = 0;
    for (int o = 0; o < 64; o++) begin
      exp_req[o]  = '0;
      exp_busy[o] = 0;
    end
    t = 1;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        h = (lat_cfg[i] < 1) ? 1 : lat_cfg[i];
`ifdef SCHED_TIMEOUT_EN
        if (lat_cfg[i] > TO) tout_hit = 1;
        if (h > TO) h = TO;
`endif
        for (int j = 0; j < h; j++) exp_req[t + j] = one << i;
        t += h + 1;
      end
    end
    for (int o = 0; o < t; o++) exp_busy[o] = 1;
    len = t + 3;

    client_en = mask;
    enable    = 1'b1;
    animate   = 1'b1;
    for (int i = 0; i < N; i++) begin
      hi_cnt[i] = 0;
      if (mask[i]) upd_done[i] = (lat_cfg[i] == 0);
    end
    for (int o = 0; o < len; o++) begin
      tick(mask);
      if (o == 0) begin
        animate = 1'b0;
        m_fcnt  = m_fcnt + 1'b1;
        vectors++;
        if (frame_cnt !== m_fcnt) begin
          miscompares++;
          $display("FAIL %s frame_cnt: got %0d expected %0d", tag, frame_cnt, m_fcnt);
        end
      end
      vectors += 2;
      if (upd_req !== exp_req[o]) begin
        miscompares++;
        $display("FAIL %s upd_req cyc %0d: got %b expected %b", tag, o, upd_req, exp_req[o]);
      end
      if (busy !== exp_busy[o]) begin
        miscompares++;
        $display("FAIL %s busy cyc %0d: got %b expected %b", tag, o, busy, exp_busy[o]);
      end
      if (rnd) begin
        screened  = ($urandom_range(0, 7) == 0);
        if (screened && exp_busy[o]) m_late = 1'b1;
        enable    = 1'($urandom_range(0, 1));
        client_en = N'($urandom);
      end
    end
    screened = 1'b0;
    enable   = 1'b1;
    if (tout_hit) m_tout = 1'b1;
    check_flags(tag);
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    tick('0);
    clr_err   = 1'b0;
    m_late    = 1'b0;
    m_overrun = 1'b0;
    m_tout    = 1'b0;
  endtask

  // Start a frame with client 1 stalled and wait for its grant.
  task automatic start_stalled(input string tag);
    lat_cfg = '{1, NEVER, 1, 1, 1};
    client_en = 5'b00011;
    animate   = 1'b1;
    tick(5'b00011);
    animate = 1'b0;
    m_fcnt  = m_fcnt + 1'b1;
    for (int k = 0; k < 20 && upd_req !== 5'b00010; k++) tick(5'b00011);
    vectors++;
    if (upd_req !== 5'b00010) begin
      miscompares++;
      $display("FAIL %s wait_grant1: got %b expected %b", tag, upd_req, 5'b00010);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; animate = 1'b0; screened = 1'b0;
    client_en = '0; upd_done = '0; clr_err = 1'b0;
    for (int i = 0; i < N; i++) begin lat_cfg[i] = 1; hi_cnt[i] = 0; end
    repeat (3) tick('0);
    vectors += 3;
    if (upd_req !== '0) begin miscompares++; $display("FAIL reset upd_req: got %b expected 0", upd_req); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (frame_cnt !== '0) begin miscompares++; $display("FAIL reset frame_cnt: got %0d expected 0", frame_cnt); end
    check_flags("reset");
    rst = 1'b0;
    repeat (5) tick('0);
  endtask

  task automatic test_basic();
    lat_cfg = '{3, 3, 3, 3, 3};
    run_frame(5'b10101, 0, "basic");
    vectors++;
    if (frame_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL basic frame_cnt_final: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_zero_mask();
    run_frame(5'b00000, 0, "zero_mask");
  endtask

  task automatic test_overrun_late();
    start_stalled("ovl");
    screened = 1'b1;
    tick(5'b00011);
    screened = 1'b0;
    m_late   = 1'b1;
    check_flags("ovl_after_screened");
    animate = 1'b1;
    tick(5'b00011);
    animate   = 1'b0;
    m_overrun = 1'b1;
    check_flags("ovl_after_animate");
    vectors += 2;
    if (frame_cnt !== m_fcnt) begin
      miscompares++;
      $display("FAIL ovl frame_cnt_hold: got %0d expected %0d", frame_cnt, m_fcnt);
    end
    if (upd_req !== 5'b00010) begin
      miscompares++;
      $display("FAIL ovl req_hold: got %b expected %b", upd_req, 5'b00010);
    end
    // Clear and a fresh late event on the same edge: late stays, overrun clears.
    clr_err  = 1'b1;
    screened = 1'b1;
    tick(5'b00011);
    clr_err   = 1'b0;
    screened  = 1'b0;
    m_overrun = 1'b0;
    check_flags("ovl_set_beats_clear");
    lat_cfg[1] = 1;
    for (int k = 0; k < 10 && busy !== 1'b0; k++) tick(5'b00011);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ovl finish: busy got %b expected 0", busy);
    end
    clear_errors();
    check_flags("ovl_cleared");
  endtask

  task automatic test_reset_mid_wait();
    start_stalled("rst_mid");
    rst = 1'b1;
    tick(5'b00011);
    rst = 1'b0;
    m_fcnt = '0; m_late = 1'b0; m_overrun = 1'b0; m_tout = 1'b0;
    vectors += 3;
    if (upd_req !== '0) begin miscompares++; $display("FAIL rst_mid upd_req: got %b expected 0", upd_req); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid busy: got %b expected 0", busy); end
    if (frame_cnt !== '0) begin miscompares++; $display("FAIL rst_mid frame_cnt: got %0d expected 0", frame_cnt); end
    check_flags("rst_mid");
    tick('0);
    lat_cfg = '{2, 1, 2, 1, 1};
    run_frame(5'b00111, 0, "rst_restart");
  endtask

  task automatic test_gating();
    enable  = 1'b0;
    animate = 1'b1;
    client_en = 5'b11111;
    tick('0);
    animate = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick('0);
      vectors += 3;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL gating busy: got %b expected 0", busy); end
      if (upd_req !== '0) begin miscompares++; $display("FAIL gating upd_req: got %b expected 0", upd_req); end
      if (frame_cnt !== m_fcnt) begin miscompares++; $display("FAIL gating frame_cnt: got %0d expected %0d", frame_cnt, m_fcnt); end
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 1) == 1) clear_errors();
      mask = N'($urandom);
      for (int i = 0; i < N; i++) lat_cfg[i] = $urandom_range(0, 4);
      run_frame(mask, 1, $sformatf("rand%0d", f));
    end
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    clear_errors();
    lat_cfg = '{NEVER, 2, 1, 1, 1};
    run_frame(5'b00011, 0, "timeout_fire");
    clear_errors();
    check_flags("timeout_cleared");
    lat_cfg = '{TO, 1, 1, 1, 1};
    run_frame(5'b00011, 0, "timeout_edge_done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_mask();
    test_overrun_late();
    test_reset_mid_wait();
    test_gating();
    test_random();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
